vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 31 +++
 rtl/vram_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Display, CPU and SRAM signal bundle for the VRAM arbiter.
// The slave side is the arbiter; the master side is its environment.
interface vram_arbiter_if;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_q;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_q,
    output disp_data, cpu_busy, cpu_ack, cpu_rdata, sram_addr, sram_we, sram_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_q,
    input  disp_data, cpu_busy, cpu_ack, cpu_rdata, sram_addr, sram_we, sram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads win every slot, CPU writes drain
// through a 4-entry FIFO, CPU reads run only once that FIFO is empty.
module vram_arbiter (
  input logic          pixel_clock,
  input logic          reset,
  vram_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {IDLE, PEND, WAIT, DONE} rd_state_t;

  rd_state_t         rd_state;
  rd_state_t         rd_state_nxt;
  wr_entry_t         fifo_mem [FIFO_DEPTH];
  wr_entry_t         head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] rd_addr;
  logic              disp_pend;
  logic              busy;
  logic              push;
  logic              rd_accept;
  logic              pop;
  logic              grant_disp;
  logic              grant_rd;

  // Slot arbitration, CPU handshake and read FSM next state.
  always_comb begin
    rd_state_nxt   = rd_state;
    head           = fifo_mem[rd_ptr];
    busy           = 1'b0;
    push           = 1'b0;
    rd_accept      = 1'b0;
    pop            = 1'b0;
    grant_disp     = 1'b0;
    grant_rd       = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_we    = 1'b0;
    bus.sram_wdata = '0;

    busy = (bus.cpu_we && (count == CNT_W'(FIFO_DEPTH))) ||
           (rd_state != IDLE) ||
           (!bus.cpu_we && (count != '0));
    push       = !reset && bus.cpu_req && !busy && bus.cpu_we;
    rd_accept  = !reset && bus.cpu_req && !busy && !bus.cpu_we;
    grant_disp = !reset && bus.disp_req;
    pop        = !reset && !bus.disp_req && (count != '0);
    grant_rd   = !reset && !grant_disp && !pop && (rd_state == PEND);

    if (grant_disp) begin
      bus.sram_addr = bus.disp_addr;
    end else if (pop) begin
      bus.sram_addr  = head.addr;
      bus.sram_we    = 1'b1;
      bus.sram_wdata = head.data;
    end else if (grant_rd) begin
      bus.sram_addr = rd_addr;
    end

    case (rd_state)
      IDLE:    if (rd_accept) rd_state_nxt = PEND;
      PEND:    if (grant_rd)  rd_state_nxt = WAIT;
      WAIT:    rd_state_nxt = DONE;
      DONE:    rd_state_nxt = IDLE;
      default: rd_state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_busy = busy;

  always_ff @(posedge pixel_clock) begin
    if (reset) rd_state <= IDLE;
    else       rd_state <= rd_state_nxt;
  end

  // Pointers, occupancy and registered read-data/ack outputs.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      rd_addr       <= '0;
      disp_pend     <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.disp_data <= '0;
    end else begin
      disp_pend   <= grant_disp;
      bus.cpu_ack <= push || (rd_state == WAIT);
      if (disp_pend)          bus.disp_data <= bus.sram_q;
      if (rd_state == WAIT)   bus.cpu_rdata <= bus.sram_q;
      if (rd_accept)          rd_addr       <= bus.cpu_addr;
      if (pop)                rd_ptr        <= rd_ptr + PTR_W'(1);
      if (push)               wr_ptr        <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge pixel_clock) begin
    if (push) fifo_mem[wr_ptr] <= {bus.cpu_addr, bus.cpu_wdata};
  end
endmodule
